rsa_job_sequencer: RTL

// Hardware responder that accepts RSA jobs from a host over a valid/ready request channel,

---
 rtl/rsa_job_sequencer_if.sv | 37 +++
 rtl/rsa_job_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rsa_job_sequencer_if.sv
// Host request/response channels and RSA control-core signals of the job sequencer.
// The slave modport is the sequencer side. The master modport is the host/core side.
interface rsa_job_sequencer_if #(
   parameter int WIDTH = 256
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_p;
   logic [WIDTH-1:0] req_q;
   logic             req_encrypt;
   logic [WIDTH-1:0] req_msg;
   logic [WIDTH-1:0] core_p;
   logic [WIDTH-1:0] core_q;
   logic             core_encrypt_decrypt;
   logic [WIDTH-1:0] core_msg_in;
   logic             core_reset;
   logic             core_reset1;
   logic [WIDTH-1:0] core_msg_out;
   logic             core_finish;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_msg;
   logic             rsp_timeout;
   logic             busy;

   modport slave (
      input  req_valid, req_p, req_q, req_encrypt, req_msg, core_msg_out, core_finish, rsp_ready,
      output req_ready, core_p, core_q, core_encrypt_decrypt, core_msg_in, core_reset, core_reset1,
             rsp_valid, rsp_msg, rsp_timeout, busy
   );

   modport master (
      output req_valid, req_p, req_q, req_encrypt, req_msg, core_msg_out, core_finish, rsp_ready,
      input  req_ready, core_p, core_q, core_encrypt_decrypt, core_msg_in, core_reset, core_reset1,
             rsp_valid, rsp_msg, rsp_timeout, busy
   );
endinterface

// File: rtl/rsa_job_sequencer.sv
// Accepts one RSA job at a time, sequences the control core through key setup and start,
// and returns the result (or a timeout indication) on a valid/ready response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
// A request is taken only in IDLE (req_ready). Once rsp_valid is raised, it stays high and
// rsp_msg/rsp_timeout stay stable until the edge on which rsp_ready is seen.
module rsa_job_sequencer #(
   parameter int WIDTH          = 256,
   parameter int SETUP_CYCLES   = 100,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   rsa_job_sequencer_if.slave    bus,
   output logic [2:0]            o_state
);
   localparam int MAX_CYCLES = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SETUP = 3'd2,
      S_START = 3'd3,
      S_WAIT  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_msg_in;
   logic [WIDTH-1:0] r_rsp_msg;
   logic             r_enc;
   logic             r_rsp_timeout;
   logic             w_accept;
   logic             w_finish_ok;
   logic             w_timeout_hit;

   // The first WAIT cycle (r_cnt == 0) may still see finish left over from the previous job.
   assign w_accept      = (r_state == S_IDLE) && bus.req_valid;
   assign w_finish_ok   = (r_state == S_WAIT) && (r_cnt != '0) && bus.core_finish;
   assign w_timeout_hit = (r_state == S_WAIT) && (r_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         S_IDLE:  if (bus.req_valid) w_next = S_LOAD;
         S_LOAD: begin
            w_cnt_next = '0;
            w_next     = S_SETUP;
         end
         S_SETUP: begin
            if (r_cnt == SETUP_LAST) w_next = S_START;
            else w_cnt_next = r_cnt + CW'(1);
         end
         S_START: begin
            w_cnt_next = '0;
            w_next     = S_WAIT;
         end
         S_WAIT: begin
            if (w_finish_ok || w_timeout_hit) w_next = S_RESP;
            else w_cnt_next = r_cnt + CW'(1);
         end
         S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p           <= '0;
         r_q           <= '0;
         r_msg_in      <= '0;
         r_enc         <= 1'b0;
         r_rsp_msg     <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_p      <= bus.req_p;
            r_q      <= bus.req_q;
            r_msg_in <= bus.req_msg;
            r_enc    <= bus.req_encrypt;
         end
         // Finish outranks a simultaneous timeout.
         if (w_finish_ok) begin
            r_rsp_msg     <= bus.core_msg_out;
            r_rsp_timeout <= 1'b0;
         end else if (w_timeout_hit) begin
            r_rsp_msg     <= '0;
            r_rsp_timeout <= 1'b1;
         end
      end
   end

   assign bus.req_ready            = (r_state == S_IDLE);
   assign bus.busy                 = (r_state != S_IDLE);
   assign bus.core_reset           = (r_state == S_LOAD);
   assign bus.core_reset1          = (r_state == S_START);
   assign bus.rsp_valid            = (r_state == S_RESP);
   assign bus.rsp_msg              = r_rsp_msg;
   assign bus.rsp_timeout          = r_rsp_timeout;
   assign bus.core_p               = r_p;
   assign bus.core_q               = r_q;
   assign bus.core_msg_in          = r_msg_in;
   assign bus.core_encrypt_decrypt = r_enc;
   assign o_state                  = r_state;
endmodule
